dm_ext: RTL and testbench
=========================

# dm_ext

Parametrised data memory for the pipelined MIPS core, used in the MEM stage in place of the fixed 1024-word, word-only data memory. Supports word, halfword and byte stores with byte-lane merging, and signed/unsigned sub-word loads. Detects misaligned and out-of-range accesses. Keeps a sticky exception record for the first faulting access, so the core or testbench can report it.

## Interface
- `ADDR_WIDTH`, default 10: word-index width; depth = 2^ADDR_WIDTH words.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- `LOG_EN`, default 1: when 1, every committed store prints a log line.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high; clears the array and the exception record.
- `WE` input 1: store enable.
- `RE` input 1: load enable; qualifies error detection only, RD is always driven.
- `mode` input 3: access type.
  - 000 word
  - 001 half signed
  - 010 half unsigned
  - 011 byte signed
  - 100 byte unsigned
  - 101–111 illegal
- `addr` input 32: byte address.
- `WD` input 32: store data; the low byte or halfword is used for sub-word stores.
- `pc` input 32: PC of the accessing instruction, used for the log line and the exception record.
- `RD` output 32: load data, extended per `mode`.
- `acc_err` output 1: combinational; the current access faults.
- `exc_valid` output 1: registered; sticky; a fault has occurred since reset.
- `exc_addr` output 32: registered; byte address of the first fault.
- `exc_pc` output 32: registered; PC of the first fault.
- `exc_code` output 2: registered cause of the first fault.
  - 01 misaligned
  - 10 out of range
  - 11 illegal mode

## Operation
- Offset: off = addr − BASE_ADDR (32-bit wrap).
- Word index: off[ADDR_WIDTH+1:2].
- Byte lane: off[1:0]; little-endian, lane 0 = bits 7:0.
- Out of range: off ≥ 4·2^ADDR_WIDTH, including negative offsets that wrap.
- Misaligned:
  - word access with off[1:0] ≠ 0
  - half access with off[0] ≠ 0
  - byte accesses are never misaligned
- Cause priority: illegal mode > out of range > misaligned.
- acc_err = (WE | RE) & (any cause).
- Store (WE=1, no fault) merges WD into the addressed word:
  - word: all 4 lanes ← WD.
  - half: lanes {off[1],0} and {off[1],1} ← WD[15:0].
  - byte: lane off[1:0] ← WD[7:0].
  - Other lanes are unchanged.
- A faulting store never writes the array.
- Load: selects the addressed byte or halfword from the current word, then sign- or zero-extends it per `mode`.
  - RD = 0 whenever the current access is out of range, misaligned or illegal.
- Log, when LOG_EN=1 and a store commits: `$display("%d@%h: *%h <= %h", $time, pc, {addr[31:2],2'b00}, merged_word)`.
  - The logged word is the full merged 32-bit word.
- Exception record:
  - On the first rising edge with acc_err=1 and exc_valid=0: exc_valid←1, exc_addr←addr, exc_pc←pc, exc_code←cause.
  - Later faults leave the record unchanged until reset.
- WE and RE both asserted: the store and the load error check both apply. RD reflects pre-store contents.

## Timing
- Reset values:
  - all array words 0
  - exc_valid 0, exc_addr 0, exc_pc 0, exc_code 00
  - the array is also zero at time 0, with no reset needed
- Reset dominates: during a reset cycle, stores are ignored, no log line is printed and no exception is captured.
- Store latency: one edge. A load at the same address in the cycle after the store returns the new data; a load in the same cycle returns the old data.
- RD and acc_err are combinational from addr/mode and the current array, with no added latency.
- The exc_* outputs update on the edge that ends the faulting cycle.
- Back-to-back stores to the same word in consecutive cycles each merge onto the previous result.

## Test plan
- Reset, then sw 0x11223344 to 0x10, then lw 0x10 → RD=0x11223344; one log line with address 0x00000010 and data 0x11223344.
- After the sw above: sb 0xAA at 0x13, then lb 0x13 → RD=0xFFFFFFAA; lbu 0x13 → 0x000000AA; lw 0x10 → 0xAA223344.
- sh 0x8001 at 0x12, then lh 0x12 → 0xFFFF8001, lhu 0x12 → 0x00008001, lw 0x10 → 0x80013344.
- sw at 0x0E (misaligned) → acc_err=1, word at 0x0C unchanged, exc_valid=1, exc_code=01, exc_addr=0x0E.
  - A subsequent out-of-range lw at 0x1000 (default params) gives acc_err=1 and RD=0, while exc_code stays 01.
- Assert reset for one cycle concurrently with WE=1 → no write, no log; then the array reads all zeros and exc_valid=0.
- ADDR_WIDTH=4, BASE_ADDR=0x1000: sw to 0x103C succeeds; sw to 0x1040 and to 0x0FFC both flag code 10 and are not written.

Source files
------------

// File: rtl/dm_ext.sv
// dm_ext: parametrised data memory with sub-word stores and loads, fault detection and a sticky record of the first fault
module dm_ext #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter bit          LOG_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic        RE,
    input  logic [2:0]  mode,
    input  logic [31:0] addr,
    input  logic [31:0] WD,
    input  logic [31:0] pc,
    output logic [31:0] RD,
    output logic        acc_err,
    output logic        exc_valid,
    output logic [31:0] exc_addr,
    output logic [31:0] exc_pc,
    output logic [1:0]  exc_code
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    logic [31:0] mem [DEPTH] = '{default: '0};
    logic [31:0] off, cur, wrep, merged;
    logic [15:0] sh;
    logic [ADDR_WIDTH-1:0] idx;
    logic [3:0] be;
    logic is_word, is_half, ill, oor, mis, fault;
    logic [1:0] cause;
    // decode the access, classify faults, build the merged store word and the extended load value
    always_comb begin
        off = addr - BASE_ADDR;
        idx = off[ADDR_WIDTH+1:2];
        cur = mem[idx];
        is_word = mode == 3'd0;
        is_half = mode == 3'd1 || mode == 3'd2;
        ill = mode > 3'd4;
        oor = (off >> (ADDR_WIDTH + 2)) != 32'd0;
        mis = is_word ? off[1:0] != 2'd0 : is_half & off[0];
        cause = ill ? 2'b11 : oor ? 2'b10 : mis ? 2'b01 : 2'b00;
        fault = cause != 2'b00;
        acc_err = (WE | RE) & fault;
        wrep = is_word ? WD : is_half ? {2{WD[15:0]}} : {4{WD[7:0]}};
        be = is_word ? 4'hF : is_half ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off[1:0];
        merged = cur;
        for (int i = 0; i < 4; i++) merged[8*i +: 8] = be[i] ? wrep[8*i +: 8] : cur[8*i +: 8];
        sh = 16'(cur >> {off[1:0], 3'b000});
        RD = fault          ? 32'd0 :
             mode == 3'd0   ? cur :
             mode == 3'd1   ? {{16{sh[15]}}, sh} :
             mode == 3'd2   ? {16'h0000, sh} :
             mode == 3'd3   ? {{24{sh[7]}}, sh[7:0]} :
                              {24'h000000, sh[7:0]};
    end
    // array update: reset clears every word, otherwise a fault-free store commits the merged word
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (WE && !fault) begin
            mem[idx] <= merged;
            if (LOG_EN) $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
        end
    end
    // sticky exception record holding only the first fault since reset
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_valid <= 1'b0;
            exc_addr <= '0;
            exc_pc <= '0;
            exc_code <= 2'b00;
        end else if (acc_err && !exc_valid) begin
            exc_valid <= 1'b1;
            exc_addr <= addr;
            exc_pc <= pc;
            exc_code <= cause;
        end
    end
endmodule

// File: tb/tb_dm_ext.sv
// tb_dm_ext: randomized and directed self-checking bench for dm_ext against a byte-array reference model
module tb_dm_ext;
    logic clk = 1'b0, reset = 1'b1;
    logic we = 1'b0, re = 1'b0;
    logic [2:0] mode = '0;
    logic [31:0] addr = '0, wd = '0, pc = '0;
    logic [31:0] rd, exc_addr, exc_pc;
    logic acc_err, exc_valid;
    logic [1:0] exc_code;
    logic s_we = 1'b0, s_re = 1'b0;
    logic [2:0] s_mode = '0;
    logic [31:0] s_addr = '0, s_wd = '0, s_pc = '0;
    logic [31:0] s_rd, s_exc_addr, s_exc_pc;
    logic s_acc_err, s_exc_valid;
    logic [1:0] s_exc_code;
    int errors = 0, checks = 0;

    logic [7:0] bm [4096];
    logic mv;
    logic [31:0] ma, mp;
    logic [1:0] mc;

    typedef struct {
        logic        w;
        logic [2:0]  m;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] e;
    } op_t;

    dm_ext dut (
        .clk(clk), .reset(reset), .WE(we), .RE(re), .mode(mode), .addr(addr), .WD(wd), .pc(pc),
        .RD(rd), .acc_err(acc_err), .exc_valid(exc_valid), .exc_addr(exc_addr), .exc_pc(exc_pc),
        .exc_code(exc_code)
    );

    dm_ext #(.ADDR_WIDTH(4), .BASE_ADDR(32'h0000_1000)) dut2 (
        .clk(clk), .reset(reset), .WE(s_we), .RE(s_re), .mode(s_mode), .addr(s_addr), .WD(s_wd),
        .pc(s_pc), .RD(s_rd), .acc_err(s_acc_err), .exc_valid(s_exc_valid), .exc_addr(s_exc_addr),
        .exc_pc(s_exc_pc), .exc_code(s_exc_code)
    );

    always #5 clk = ~clk;

    function automatic int unsigned m_size(input logic [2:0] m);
        return (m == 3'd0) ? 4 : (m <= 3'd2) ? 2 : 1;
    endfunction

    function automatic logic [1:0] m_cause(input logic [2:0] m, input logic [31:0] a);
        if (m > 3'd4) return 2'b11;
        if (a >= 32'd4096) return 2'b10;
        if (a % m_size(m) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] m, input logic [31:0] a);
        int v;
        if (m_cause(m, a) != 2'b00) return 32'd0;
        case (m)
            3'd0: v = {bm[a+3], bm[a+2], bm[a+1], bm[a]};
            3'd1: v = shortint'({bm[a+1], bm[a]});
            3'd2: v = {16'h0000, bm[a+1], bm[a]};
            3'd3: v = byte'(bm[a]);
            default: v = {24'h000000, bm[a]};
        endcase
        return v;
    endfunction

    task automatic set(input logic w, input logic r, input logic [2:0] m, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] p);
        we = w; re = r; mode = m; addr = a; wd = d; pc = p;
    endtask

    task automatic s_set(input logic w, input logic r, input logic [2:0] m, input logic [31:0] a,
                         input logic [31:0] d);
        s_we = w; s_re = r; s_mode = m; s_addr = a; s_wd = d; s_pc = 32'h0000_0800;
    endtask

    task automatic step;
        logic [1:0] c;
        @(posedge clk);
        if (reset) begin
            foreach (bm[i]) bm[i] = 8'h00;
            mv = 1'b0; ma = '0; mp = '0; mc = 2'b00;
        end else begin
            c = m_cause(mode, addr);
            if (we && c == 2'b00)
                for (int k = 0; k < int'(m_size(mode)); k++) bm[addr+k] = wd[8*k +: 8];
            if ((we || re) && c != 2'b00 && !mv) begin
                mv = 1'b1; ma = addr; mp = pc; mc = c;
            end
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        set(0, 0, 0, 0, 0, 0);
        s_set(0, 0, 0, 32'h1000, 0);
        step;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        set(1, 1, 0, 32'h10, 32'h1234_5678, 0);
        step;
        step;
        reset = 1'b0;
        set(0, 1, 0, 32'h10, 0, 0);
        #1;
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_rd got=%h want=%h", rd, 32'd0); end
        checks++;
        if ({exc_valid, exc_addr, exc_pc, exc_code} !== 67'd0)
            begin errors++; $display("FAIL reset_exc got=%b/%h/%h/%b want=0", exc_valid, exc_addr, exc_pc, exc_code); end
        step;
    endtask

    task automatic test_basic;
        op_t ops [10] = '{
            '{1'b1, 3'd0, 32'h10, 32'h1122_3344, 32'h0},
            '{1'b0, 3'd0, 32'h10, 32'h0, 32'h1122_3344},
            '{1'b1, 3'd3, 32'h13, 32'hDEAD_BEAA, 32'h0},
            '{1'b0, 3'd3, 32'h13, 32'h0, 32'hFFFF_FFAA},
            '{1'b0, 3'd4, 32'h13, 32'h0, 32'h0000_00AA},
            '{1'b0, 3'd0, 32'h10, 32'h0, 32'hAA22_3344},
            '{1'b1, 3'd1, 32'h12, 32'h5555_8001, 32'h0},
            '{1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFF_8001},
            '{1'b0, 3'd2, 32'h12, 32'h0, 32'h0000_8001},
            '{1'b0, 3'd0, 32'h10, 32'h0, 32'h8001_3344}
        };
        foreach (ops[i]) begin
            set(ops[i].w, !ops[i].w, ops[i].m, ops[i].a, ops[i].d, 32'h0040_0000 + 4 * i);
            #1;
            checks++;
            if (acc_err !== 1'b0) begin errors++; $display("FAIL basic_err[%0d] got=%b want=0", i, acc_err); end
            if (!ops[i].w) begin
                checks++;
                if (rd !== ops[i].e) begin errors++; $display("FAIL basic_rd[%0d] got=%h want=%h", i, rd, ops[i].e); end
            end
            step;
        end
    endtask

    task automatic test_faults;
        set(1, 0, 0, 32'h0E, 32'hFFFF_FFFF, 32'h0000_0500);
        #1;
        checks++;
        if (acc_err !== 1'b1) begin errors++; $display("FAIL mis_err got=%b want=1", acc_err); end
        step;
        checks++;
        if ({exc_valid, exc_addr, exc_pc, exc_code} !== {1'b1, 32'h0E, 32'h500, 2'b01})
            begin errors++; $display("FAIL mis_exc got=%b/%h/%h/%b want=1/0000000e/00000500/01", exc_valid, exc_addr, exc_pc, exc_code); end
        set(0, 1, 0, 32'h0C, 0, 0);
        #1;
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL mis_nowrite got=%h want=0", rd); end
        set(0, 1, 0, 32'h1000, 0, 32'h0000_0600);
        #1;
        checks++;
        if (acc_err !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL oor_load got=%b/%h want=1/0", acc_err, rd); end
        step;
        checks++;
        if (exc_code !== 2'b01 || exc_addr !== 32'h0E) begin errors++; $display("FAIL exc_sticky got=%b/%h want=01/0000000e", exc_code, exc_addr); end
        set(0, 1, 3'd5, 32'h10, 0, 0);
        #1;
        checks++;
        if (acc_err !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL ill_mode got=%b/%h want=1/0", acc_err, rd); end
        set(0, 0, 0, 32'h0E, 0, 0);
        #1;
        checks++;
        if (acc_err !== 1'b0) begin errors++; $display("FAIL idle_err got=%b want=0", acc_err); end
        step;
    endtask

    task automatic test_reset_we;
        reset = 1'b1;
        set(1, 0, 0, 32'h20, 32'hCAFE_BABE, 0);
        step;
        reset = 1'b0;
        set(0, 1, 0, 32'h20, 0, 0);
        #1;
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL rst_we_rd got=%h want=0", rd); end
        set(0, 1, 0, 32'h10, 0, 0);
        #1;
        checks++;
        if (rd !== 32'd0 || exc_valid !== 1'b0) begin errors++; $display("FAIL rst_clear got=%h/%b want=0/0", rd, exc_valid); end
        step;
    endtask

    task automatic test_back_to_back;
        set(1, 1, 0, 32'h30, 32'h0102_0304, 0);
        #1;
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL same_cycle_old got=%h want=0", rd); end
        step;
        set(1, 0, 3, 32'h31, 32'h0000_00B1, 0); step;
        set(1, 0, 4, 32'h33, 32'h0000_00D3, 0); step;
        set(1, 1, 1, 32'h30, 32'h0000_7777, 0);
        #1;
        checks++;
        if (rd !== 32'hFFFF_B104) begin errors++; $display("FAIL b2b_pre got=%h want=ffffb104", rd); end
        step;
        set(1, 1, 0, 32'h30, 32'hFFFF_FFFF, 0);
        #1;
        checks++;
        if (rd !== 32'hD302_7777) begin errors++; $display("FAIL b2b_merge got=%h want=d3027777", rd); end
        step;
        set(0, 1, 0, 32'h30, 0, 0);
        #1;
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_final got=%h want=ffffffff", rd); end
        step;
    endtask

    task automatic test_params;
        pulse_reset;
        s_set(1, 0, 0, 32'h103C, 32'h5A5A_5A5A);
        #1;
        checks++;
        if (s_acc_err !== 1'b0) begin errors++; $display("FAIL p_top_err got=%b want=0", s_acc_err); end
        step;
        s_set(0, 1, 0, 32'h103C, 0);
        #1;
        checks++;
        if (s_rd !== 32'h5A5A_5A5A) begin errors++; $display("FAIL p_top_rd got=%h want=5a5a5a5a", s_rd); end
        s_set(1, 0, 0, 32'h1040, 32'h1111_1111);
        #1;
        checks++;
        if (s_acc_err !== 1'b1) begin errors++; $display("FAIL p_hi_err got=%b want=1", s_acc_err); end
        step;
        checks++;
        if (s_exc_valid !== 1'b1 || s_exc_code !== 2'b10 || s_exc_addr !== 32'h1040)
            begin errors++; $display("FAIL p_hi_exc got=%b/%b/%h want=1/10/00001040", s_exc_valid, s_exc_code, s_exc_addr); end
        s_set(0, 1, 0, 32'h1000, 0);
        #1;
        checks++;
        if (s_rd !== 32'd0) begin errors++; $display("FAIL p_hi_nowrite got=%h want=0", s_rd); end
        pulse_reset;
        s_set(1, 0, 0, 32'h103C, 32'h5A5A_5A5A); step;
        s_set(1, 0, 0, 32'h0FFC, 32'h2222_2222);
        #1;
        checks++;
        if (s_acc_err !== 1'b1) begin errors++; $display("FAIL p_lo_err got=%b want=1", s_acc_err); end
        step;
        checks++;
        if (s_exc_code !== 2'b10 || s_exc_addr !== 32'h0FFC) begin errors++; $display("FAIL p_lo_exc got=%b/%h want=10/00000ffc", s_exc_code, s_exc_addr); end
        s_set(0, 1, 0, 32'h103C, 0);
        #1;
        checks++;
        if (s_rd !== 32'h5A5A_5A5A) begin errors++; $display("FAIL p_lo_nowrite got=%h want=5a5a5a5a", s_rd); end
        s_set(0, 0, 0, 32'h1000, 0);
        step;
    endtask

    task automatic test_random;
        logic [31:0] a, exp_rd;
        logic exp_err;
        int sel;
        pulse_reset;
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            a = (sel < 7) ? 32'($urandom_range(0, 63)) :
                (sel == 7) ? 32'hFFC + 32'($urandom_range(0, 7)) :
                (sel == 8) ? 32'($urandom) : 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7)),
                a, 32'($urandom), 32'($urandom));
            exp_rd = m_load(mode, addr);
            exp_err = (we || re) && m_cause(mode, addr) != 2'b00;
            #1;
            checks++;
            if (rd !== exp_rd || acc_err !== exp_err)
                begin errors++; $display("FAIL rnd_access[%0d] got=%h/%b want=%h/%b", i, rd, acc_err, exp_rd, exp_err); end
            step;
            checks++;
            if ({exc_valid, exc_addr, exc_pc, exc_code} !== {mv, ma, mp, mc})
                begin errors++; $display("FAIL rnd_exc[%0d] got=%b/%h/%h/%b want=%b/%h/%h/%b", i, exc_valid, exc_addr, exc_pc, exc_code, mv, ma, mp, mc); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_faults;
        test_reset_we;
        test_back_to_back;
        test_params;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
